// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive framer: strips preamble/SFD, delimits and qualifies frames, keeps stats.
// Define GMII_RX_FCS_CHECK_EN to add the CRC-32 FCS check.
module gmii_rx_frame_ctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int MAX_PRE = 7
) (
    input  logic        RXCLK_i,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [7:0]  GMII_RX_RXD_i,
    input  logic        GMII_RX_DV_i,
    input  logic        GMII_RX_ER_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_sof_o,
    output logic        rx_eof_o,
    output logic        rx_good_o,
    output logic [15:0] frame_len_o,
    output logic        busy_o,
    output logic [15:0] good_cnt_o,
    output logic [15:0] bad_cnt_o,
    output logic [15:0] drop_cnt_o,
    output logic        fcs_err_o
);

    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [7:0]  PRE_LIM  = 8'(MAX_PRE);
    localparam logic [15:0] LEN_MIN  = 16'(MIN_LEN);
    localparam logic [15:0] LEN_MAX  = 16'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
    state_t state, state_nx;

    logic       dv, er;
    logic [7:0] rxd;
    logic [7:0] pre_cnt, hold;
    logic       hold_vld, first, err;
    logic [15:0] len;
    logic       go_pre, pre_inc, sfd, drop_hit, take, close;
    logic       fcs_ok, frame_ok;

    assign dv  = GMII_RX_DV_i;
    assign er  = GMII_RX_ER_i;
    assign rxd = GMII_RX_RXD_i;

    always_ff @(posedge RXCLK_i) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        go_pre   = 1'b0;
        pre_inc  = 1'b0;
        sfd      = 1'b0;
        drop_hit = 1'b0;
        take     = 1'b0;
        close    = 1'b0;
        unique case (state)
            IDLE: begin
                // DV low with ER high is carrier extension and is ignored
                if (enable_i && dv) begin
                    if (rxd == PRE_BYTE && !er) begin
                        state_nx = PRE;
                        go_pre   = 1'b1;
                    end else begin
                        state_nx = DROP;
                        drop_hit = 1'b1;
                    end
                end
            end
            PRE: begin
                if (!dv) begin
                    state_nx = IDLE;
                    drop_hit = 1'b1;
                end else if (er) begin
                    state_nx = DROP;
                    drop_hit = 1'b1;
                end else if (rxd == PRE_BYTE) begin
                    if (pre_cnt >= PRE_LIM) begin
                        state_nx = DROP;
                        drop_hit = 1'b1;
                    end else begin
                        pre_inc = 1'b1;
                    end
                end else if (rxd == SFD_BYTE) begin
                    state_nx = DATA;
                    sfd      = 1'b1;
                end else begin
                    state_nx = DROP;
                    drop_hit = 1'b1;
                end
            end
            DATA: begin
                if (dv) begin
                    take = 1'b1;
                end else begin
                    state_nx = IDLE;
                    close    = 1'b1;
                end
            end
            DROP: begin
                if (!dv) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy_o   = (state != IDLE);
    assign frame_ok = (len >= LEN_MIN) && (len <= LEN_MAX) && !err && fcs_ok;

    always_ff @(posedge RXCLK_i) begin
        if (reset) begin
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            rx_sof_o    <= 1'b0;
            rx_eof_o    <= 1'b0;
            rx_good_o   <= 1'b0;
            frame_len_o <= '0;
            good_cnt_o  <= '0;
            bad_cnt_o   <= '0;
            drop_cnt_o  <= '0;
            pre_cnt     <= '0;
            hold        <= '0;
            hold_vld    <= 1'b0;
            first       <= 1'b0;
            err         <= 1'b0;
            len         <= '0;
        end else begin
            rx_valid_o  <= 1'b0;
            rx_sof_o    <= 1'b0;
            rx_eof_o    <= 1'b0;
            rx_good_o   <= 1'b0;
            frame_len_o <= '0;
            if (go_pre)       pre_cnt <= 8'd1;
            else if (pre_inc) pre_cnt <= pre_cnt + 8'd1;
            // a burst that closes with no data byte has nothing to report
            if (drop_hit || (close && !hold_vld))
                drop_cnt_o <= drop_cnt_o + 16'd1;
            if (sfd) begin
                len      <= '0;
                err      <= 1'b0;
                first    <= 1'b1;
                hold_vld <= 1'b0;
            end
            if (take) begin
                hold     <= rxd;
                hold_vld <= 1'b1;
                if (len != 16'hFFFF) len <= len + 16'd1;
                if (er) err <= 1'b1;
                if (hold_vld) begin
                    rx_data_o  <= hold;
                    rx_valid_o <= 1'b1;
                    rx_sof_o   <= first;
                    first      <= 1'b0;
                end
            end
            if (close) begin
                hold_vld <= 1'b0;
                if (hold_vld) begin
                    rx_data_o   <= hold;
                    rx_valid_o  <= 1'b1;
                    rx_sof_o    <= first;
                    rx_eof_o    <= 1'b1;
                    rx_good_o   <= frame_ok;
                    frame_len_o <= len;
                    first       <= 1'b0;
                    if (frame_ok) good_cnt_o <= good_cnt_o + 16'd1;
                    else          bad_cnt_o  <= bad_cnt_o + 16'd1;
                end
            end
        end
    end

`ifdef GMII_RX_FCS_CHECK_EN
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ({32{r[0] ^ d[i]}} & 32'hEDB88320);
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    always_ff @(posedge RXCLK_i) begin
        if (reset) begin
            crc       <= '1;
            fcs_err_o <= 1'b0;
        end else begin
            fcs_err_o <= close && hold_vld && !fcs_ok;
            if (sfd)       crc <= '1;
            else if (take) crc <= crc_byte(crc, rxd);
        end
    end

    // register is LSB-first, residue constant is MSB-first
    assign fcs_ok = (rev32(crc) == RESIDUE);
`else
    assign fcs_ok    = 1'b1;
    assign fcs_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Randomized bench for gmii_rx_frame_ctrl against a frame-level reference model.
// Define GMII_RX_FCS_CHECK_EN to match an FCS-checking build.
module tb_gmii_rx_frame_ctrl;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
`ifdef GMII_RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable_i, dv, er;
    logic [7:0]  rxd;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, rx_sof_o, rx_eof_o, rx_good_o;
    logic [15:0] frame_len_o;
    logic        busy_o, fcs_err_o;
    logic [15:0] good_cnt_o, bad_cnt_o, drop_cnt_o;

    always #4 clk = ~clk;

    gmii_rx_frame_ctrl #(
        .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .MAX_PRE(7)
    ) dut (
        .RXCLK_i(clk), .reset(reset), .enable_i(enable_i),
        .GMII_RX_RXD_i(rxd), .GMII_RX_DV_i(dv), .GMII_RX_ER_i(er),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_sof_o(rx_sof_o), .rx_eof_o(rx_eof_o),
        .rx_good_o(rx_good_o), .frame_len_o(frame_len_o),
        .busy_o(busy_o), .good_cnt_o(good_cnt_o),
        .bad_cnt_o(bad_cnt_o), .drop_cnt_o(drop_cnt_o),
        .fcs_err_o(fcs_err_o)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic        sof, eof, good, fcs;
        logic [15:0] len;
    } rec_t;

    rec_t       obs_q[$], exp_q[$];
    logic [7:0] pl[$], tx_d[$];
    logic       tx_e[$];
    int         tx_first;
    int         vecs = 0, errs = 0;
    int         exp_good = 0, exp_bad = 0, exp_drop = 0;
    bit         en = 1'b1, mon_on = 1'b0;
    int         cyc = 0, first_cyc = 0, sof_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_on) begin
            if (rx_valid_o) begin
                rec_t r;
                r.d = rx_data_o;   r.sof = rx_sof_o;
                r.eof = rx_eof_o;  r.good = rx_good_o;
                r.fcs = fcs_err_o; r.len = frame_len_o;
                obs_q.push_back(r);
                if (rx_sof_o) sof_cyc = cyc;
            end else begin
                chk("qualify", {29'd0, rx_sof_o, rx_eof_o, fcs_err_o}, 32'd0);
            end
        end
    end

    // Standard Ethernet CRC-32 of pl[0..n-1], final value as transmitted
    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c ^= {24'd0, pl[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic drive(input logic v, input logic e, input logic [7:0] d);
        dv = v; er = e; rxd = d;
        @(posedge clk);
        #1;
    endtask

    task automatic make_payload(input int n, input bit good_fcs);
        logic [31:0] c;
        pl.delete();
        if (n < 5) begin
            repeat (n) pl.push_back(8'($urandom));
            return;
        end
        repeat (n - 4) pl.push_back(8'($urandom));
        c = crc32(n - 4);
        pl.push_back(c[7:0]);   pl.push_back(c[15:8]);
        pl.push_back(c[23:16]); pl.push_back(c[31:24]);
        if (!good_fcs)
            pl[n-1-$urandom_range(0, 3)] ^= 8'(1 << $urandom_range(0, 7));
    endtask

    task automatic model_frame(input bit er_any);
        int   n;
        bit   fok;
        rec_t r;
        n = pl.size();
        if (!en) return;
        fok = 1'b0;
        if (n >= 4)
            fok = (crc32(n - 4) == {pl[n-1], pl[n-2], pl[n-3], pl[n-4]});
        for (int i = 0; i < n; i++) begin
            r = '0;
            r.d = pl[i];
            r.sof = (i == 0);
            r.eof = (i == n - 1);
            if (r.eof) begin
                r.len = (n > 65535) ? 16'hFFFF : 16'(n);
                r.good = (n >= MIN_LEN) && (n <= MAX_LEN) && !er_any
                         && (fok || !FCS_EN);
                r.fcs = FCS_EN && !fok;
                if (r.good) exp_good++;
                else        exp_bad++;
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic load_frame(input int npre, input int er_at);
        tx_d.delete(); tx_e.delete();
        repeat (npre) begin tx_d.push_back(8'h55); tx_e.push_back(1'b0); end
        tx_d.push_back(8'hD5); tx_e.push_back(1'b0);
        tx_first = tx_d.size();
        foreach (pl[i]) begin
            tx_d.push_back(pl[i]);
            tx_e.push_back(i == er_at);
        end
        model_frame(er_at >= 0 && er_at < pl.size());
    endtask

    task automatic tx(input int ifg, input int en_off);
        for (int i = 0; i < tx_d.size(); i++) begin
            if (i == en_off) enable_i = 1'b0;
            drive(1'b1, tx_e[i], tx_d[i]);
            if (i == tx_first) first_cyc = cyc;
        end
        chk("busy", busy_o, en);
        repeat (ifg) drive(1'b0, 1'($urandom), 8'($urandom));
        if (en_off >= 0) enable_i = 1'b1;
    endtask

    task automatic flush();
        int n;
        repeat (4) drive(1'b0, 1'($urandom), 8'($urandom));
        chk("nbytes", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("data", obs_q[i].d, exp_q[i].d);
            chk("sof", obs_q[i].sof, exp_q[i].sof);
            chk("eof", obs_q[i].eof, exp_q[i].eof);
            if (exp_q[i].eof) begin
                chk("good", obs_q[i].good, exp_q[i].good);
                chk("len", obs_q[i].len, exp_q[i].len);
                chk("fcs_err", obs_q[i].fcs, exp_q[i].fcs);
            end
        end
        obs_q.delete(); exp_q.delete();
        chk("good_cnt", good_cnt_o, 16'(exp_good));
        chk("bad_cnt", bad_cnt_o, 16'(exp_bad));
        chk("drop_cnt", drop_cnt_o, 16'(exp_drop));
        chk("idle_busy", busy_o, 1'b0);
    endtask

    task automatic drop_burst(input int kind);
        logic [7:0] b;
        logic       e;
        tx_d.delete(); tx_e.delete();
        tx_first = -1;
        case (kind)
            0: begin
                b = 8'($urandom); e = 1'($urandom);
                if (b == 8'h55 && !e) e = 1'b1;
                tx_d.push_back(b); tx_e.push_back(e);
                repeat ($urandom_range(0, 5)) begin
                    tx_d.push_back(8'($urandom)); tx_e.push_back(1'($urandom));
                end
            end
            1: begin
                repeat ($urandom_range(1, 6)) begin
                    tx_d.push_back(8'h55); tx_e.push_back(1'b0);
                end
                b = 8'($urandom); e = 1'b0;
                if (b == 8'h55 || b == 8'hD5) e = 1'b1;
                tx_d.push_back(b); tx_e.push_back(e);
                repeat ($urandom_range(0, 4)) begin
                    tx_d.push_back(8'($urandom)); tx_e.push_back(1'($urandom));
                end
            end
            2: begin
                repeat ($urandom_range(8, 10)) begin
                    tx_d.push_back(8'h55); tx_e.push_back(1'b0);
                end
                tx_d.push_back(8'hD5); tx_e.push_back(1'b0);
                repeat (10) begin
                    tx_d.push_back(8'($urandom)); tx_e.push_back(1'b0);
                end
            end
            default: begin
                repeat ($urandom_range(1, 7)) begin
                    tx_d.push_back(8'h55); tx_e.push_back(1'b0);
                end
            end
        endcase
        if (en) exp_drop++;
    endtask

    initial begin
        reset = 1'b1; enable_i = 1'b1;
        dv = 1'b0; er = 1'b0; rxd = 8'h00;
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        chk("rst_valid", rx_valid_o, 1'b0);
        chk("rst_data", rx_data_o, 8'h00);
        chk("rst_eof", rx_eof_o, 1'b0);
        chk("rst_len", frame_len_o, 16'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_cnts", {good_cnt_o, bad_cnt_o}, 32'd0);
        chk("rst_drop", drop_cnt_o, 16'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        mon_on = 1'b1;

        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        if (FCS_EN) begin
            logic [31:0] c;
            c = crc32(60);
            pl[60] = c[7:0];   pl[61] = c[15:8];
            pl[62] = c[23:16]; pl[63] = c[31:24];
        end
        load_frame(7, -1);
        tx(3, -1);
        flush();
        chk("t1_latency", sof_cyc - first_cyc, 32'd1);
        chk("t1_good_cnt", good_cnt_o, 16'd1);

        make_payload(10, 1'b1);   load_frame(7, -1); tx(2, -1);
        make_payload(1519, 1'b1); load_frame(7, -1); tx(2, -1);
        make_payload(1, 1'b1);    load_frame(3, -1); tx(1, -1);
        flush();
        chk("t2_bad_cnt", bad_cnt_o, 16'd3);

        make_payload(100, 1'b1);  load_frame(7, 19); tx(2, -1);
        flush();

        tx_d.delete(); tx_e.delete(); tx_first = -1;
        repeat (5) begin tx_d.push_back(8'h0E); tx_e.push_back(1'b1); end
        exp_drop++;
        tx(2, -1);
        tx_d = '{8'h55, 8'h55, 8'h12}; tx_e = '{1'b0, 1'b0, 1'b0};
        exp_drop++;
        tx(2, -1);
        flush();
        chk("t4_drop_cnt", drop_cnt_o, 16'd2);

        make_payload(64, 1'b1); load_frame(7, -1); tx(1, -1);
        make_payload(64, 1'b1); load_frame(7, -1); tx(1, -1);
        flush();

        make_payload(64, 1'b1); load_frame(7, -1);
        for (int i = 0; i < 40; i++) drive(1'b1, tx_e[i], tx_d[i]);
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        chk("midrst_valid", rx_valid_o, 1'b0);
        chk("midrst_eof", rx_eof_o, 1'b0);
        chk("midrst_cnt", good_cnt_o, 16'd0);
        chk("midrst_busy", busy_o, 1'b0);
        reset = 1'b0;
        obs_q.delete(); exp_q.delete();
        exp_good = 0; exp_bad = 0; exp_drop = 0;
        flush();

        make_payload(80, 1'b0); load_frame(7, -1); tx(2, -1);
        en = 1'b0; enable_i = 1'b0;
        make_payload(70, 1'b1); load_frame(7, -1); tx(2, -1);
        en = 1'b1; enable_i = 1'b1;
        flush();

        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = $urandom_range(0, 10);
            case (kind)
                0, 1: begin
                    make_payload($urandom_range(64, 300), 1'b1);
                    load_frame($urandom_range(1, 7), -1);
                    tx($urandom_range(1, 3), -1);
                end
                2: begin
                    make_payload($urandom_range(1, 63), 1'b1);
                    load_frame($urandom_range(1, 7), -1);
                    tx($urandom_range(1, 3), -1);
                end
                3: begin
                    make_payload($urandom_range(64, 200), 1'b1);
                    load_frame(7, $urandom_range(0, 63));
                    tx($urandom_range(1, 3), -1);
                end
                4: begin
                    make_payload($urandom_range(64, 200), 1'b0);
                    load_frame(7, -1);
                    tx($urandom_range(1, 3), -1);
                end
                5, 6, 7, 8: begin
                    drop_burst(kind - 5);
                    tx($urandom_range(1, 3), -1);
                end
                9: begin
                    en = 1'b0; enable_i = 1'b0;
                    make_payload($urandom_range(64, 100), 1'b1);
                    load_frame(7, -1);
                    tx($urandom_range(1, 3), -1);
                    en = 1'b1; enable_i = 1'b1;
                end
                default: begin
                    make_payload($urandom_range(64, 150), 1'b1);
                    load_frame(7, -1);
                    tx($urandom_range(1, 3), tx_first + 5);
                end
            endcase
            if (it % 3 == 2) flush();
        end
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
